sdram_arbiter: RTL
==================

// Module: sdram_arbiter
// PURPOSE
//  Command arbiter sitting directly downstream of sdram_init, sdram_aref, sdram_write and
//  sdram_read. It grants the SDRAM command/address bus to one sub-controller at a time.
//  It muxes the granted {cmd,bank,addr} onto the device pins and owns the tristate DQ driver.
//  Priority: auto-refresh > write > read. Init owns the bus until init_end.
// PARAMETERS
//  ADDR_W   13      SDRAM row/column address width
//  BANK_W   2       bank address width
//  DATA_W   16      DQ width
// PORTS
//  arb_clk        in   1       system clock; all logic on rising edge
//  arb_rst        in   1       synchronous reset, active-high
//  init_end       in   1       sdram_init done (level; stays high)
//  init_cmd       in   4       init command {cs_n,ras_n,cas_n,we_n}
//  init_bank      in   BANK_W  init bank
//  init_addr      in   ADDR_W  init address
//  aref_req       in   1       refresh request (level, held until granted)
//  aref_end       in   1       refresh sequence done (1-cycle pulse)
//  aref_cmd/bank/addr  in  4/BANK_W/ADDR_W  refresh bus
//  aref_en        out  1       refresh grant
//  wr_req         in   1       write request (level)
//  wr_end         in   1       write burst done (1-cycle pulse)
//  wr_cmd/bank/addr    in  4/BANK_W/ADDR_W  write bus
//  wr_sdram_en    in   1       write module drives DQ this cycle
//  wr_sdram_data  in   DATA_W  write data
//  wr_en          out  1       write grant
//  rd_req         in   1       read request (level)
//  rd_end         in   1       read burst done (1-cycle pulse)
//  rd_cmd/bank/addr    in  4/BANK_W/ADDR_W  read bus
//  rd_en          out  1       read grant
//  sdram_cke      out  1       constant 1
//  sdram_cs_n/ras_n/cas_n/we_n  out 1 each  bits [3:0] of selected cmd
//  sdram_ba       out  BANK_W  selected bank
//  sdram_addr     out  ADDR_W  selected address
//  sdram_dq       inout DATA_W wr_sdram_data when wr_sdram_en && state==WRITE, else 'z
// BEHAVIOUR
//  FSM states: INIT, ARBIT, AREF, WRITE, READ. Reset -> INIT; aref_en/wr_en/rd_en = 0.
//  INIT: pins = init_* (combinational). Go to ARBIT the cycle after init_end is sampled 1.
//  ARBIT: pins = NOP (cmd 4'b0111, ba all-1, addr all-1).
//   Sample requests in priority order aref_req > wr_req > rd_req.
//   The winner's state is entered next cycle, and its *_en is registered high the same cycle.
//   No request -> stay in ARBIT.
//  AREF/WRITE/READ: pins = granted module's cmd/bank/addr. *_en stays 1.
//   On *_end = 1: return to ARBIT next cycle and clear *_en. Requests are not sampled this cycle.
//   Minimum 1 NOP cycle in ARBIT between grants.
//  Grant is exactly one-hot or zero. Ungranted modules' pin inputs and *_end are ignored.
//  Requests arriving mid-grant are held by the requester. They are arbitrated at the next ARBIT.
//   A refresh pending with write/read pending always wins that ARBIT.
//  Simultaneous aref_req+wr_req+rd_req in ARBIT -> AREF.
//  *_end asserted in a non-matching state -> ignored.
//  arb_rst mid-burst -> INIT next edge, all grants 0, DQ released the same cycle (combinational on state).
//  Latency: req sampled in ARBIT -> *_en=1 one cycle later. *_end -> *_en=0 one cycle later.
// TESTING
//  1 Reset, init_end=0, init_cmd=4'b0010 -> pins follow init bus; all *_en=0; sdram_dq='z.
//  2 init_end=1, no reqs -> ARBIT by 2nd edge; pins NOP 4'b0111, ba=2'b11, addr=13'h1FFF.
//  3 wr_req=1 -> wr_en=1 next cycle; wr_cmd=4'b0100 on pins.
//    wr_sdram_en=1, data 16'hA5A5 -> DQ=A5A5. wr_end pulse -> wr_en=0 next cycle.
//  4 aref_req, wr_req, rd_req all raised same cycle -> AREF granted first.
//    After aref_end -> WRITE. After wr_end -> READ. 1 NOP cycle between each.
//  5 aref_req raised during 10-beat READ -> READ completes untouched; AREF granted after rd_end+ARBIT.
//  6 arb_rst=1 during WRITE with wr_sdram_en=1 -> next edge state INIT, wr_en=0, DQ='z.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// Command/address bus between the SDRAM sub-controllers and the arbiter, plus the device pin group.
// The master side is the arbiter; the slave side is the set of sub-controllers and the device.
interface sdram_arbiter_if #(
   parameter int ADDR_W = 13,
   parameter int BANK_W = 2,
   parameter int DATA_W = 16
);
   logic              init_end;
   logic [3:0]        init_cmd;
   logic [BANK_W-1:0] init_bank;
   logic [ADDR_W-1:0] init_addr;

   logic              aref_req;
   logic              aref_end;
   logic [3:0]        aref_cmd;
   logic [BANK_W-1:0] aref_bank;
   logic [ADDR_W-1:0] aref_addr;
   logic              aref_en;

   logic              wr_req;
   logic              wr_end;
   logic [3:0]        wr_cmd;
   logic [BANK_W-1:0] wr_bank;
   logic [ADDR_W-1:0] wr_addr;
   logic              wr_sdram_en;
   logic [DATA_W-1:0] wr_sdram_data;
   logic              wr_en;

   logic              rd_req;
   logic              rd_end;
   logic [3:0]        rd_cmd;
   logic [BANK_W-1:0] rd_bank;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_en;

   logic              sdram_cke;
   logic              sdram_cs_n;
   logic              sdram_ras_n;
   logic              sdram_cas_n;
   logic              sdram_we_n;
   logic [BANK_W-1:0] sdram_ba;
   logic [ADDR_W-1:0] sdram_addr;

   modport master (
      input  init_end, init_cmd, init_bank, init_addr,
      input  aref_req, aref_end, aref_cmd, aref_bank, aref_addr,
      output aref_en,
      input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
      output wr_en,
      input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
      output rd_en,
      output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
      output sdram_ba, sdram_addr
   );

   modport slave (
      output init_end, init_cmd, init_bank, init_addr,
      output aref_req, aref_end, aref_cmd, aref_bank, aref_addr,
      input  aref_en,
      output wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
      input  wr_en,
      output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
      input  rd_en,
      input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
      input  sdram_ba, sdram_addr
   );
endinterface

// File: rtl/sdram_arbiter.sv
// SDRAM command arbiter: grants the command bus to init, refresh, write or read (refresh > write > read)
// and owns the tristate DQ driver, which is enabled only while the write controller holds the bus.
module sdram_arbiter #(
   parameter int ADDR_W = 13,
   parameter int BANK_W = 2,
   parameter int DATA_W = 16
) (
   input  logic              arb_clk,
   input  logic              arb_rst,
   sdram_arbiter_if.master   bus,
   inout  wire  [DATA_W-1:0] sdram_dq
);

   localparam logic [2:0] INIT  = 3'd0;
   localparam logic [2:0] ARBIT = 3'd1;
   localparam logic [2:0] AREF  = 3'd2;
   localparam logic [2:0] WRITE = 3'd3;
   localparam logic [2:0] READ  = 3'd4;

   localparam logic [3:0] CMD_NOP = 4'b0111;

   logic [2:0]        state_q, state_d;
   logic              aref_en_q, aref_en_d;
   logic              wr_en_q, wr_en_d;
   logic              rd_en_q, rd_en_d;

   logic [3:0]        cmd_sel;
   logic [BANK_W-1:0] ba_sel;
   logic [ADDR_W-1:0] addr_sel;

   // Next-state: each *_end is only honoured in its own grant state, so stray pulses are ignored.
   always_comb begin
      state_d   = state_q;
      aref_en_d = aref_en_q;
      wr_en_d   = wr_en_q;
      rd_en_d   = rd_en_q;
      case (state_q)
         INIT: begin
            if (bus.init_end) state_d = ARBIT;
         end
         ARBIT: begin
            if (bus.aref_req) begin
               state_d   = AREF;
               aref_en_d = 1'b1;
            end else if (bus.wr_req) begin
               state_d = WRITE;
               wr_en_d = 1'b1;
            end else if (bus.rd_req) begin
               state_d = READ;
               rd_en_d = 1'b1;
            end
         end
         AREF: begin
            if (bus.aref_end) begin
               state_d   = ARBIT;
               aref_en_d = 1'b0;
            end
         end
         WRITE: begin
            if (bus.wr_end) begin
               state_d = ARBIT;
               wr_en_d = 1'b0;
            end
         end
         READ: begin
            if (bus.rd_end) begin
               state_d = ARBIT;
               rd_en_d = 1'b0;
            end
         end
         default: begin
            state_d   = INIT;
            aref_en_d = 1'b0;
            wr_en_d   = 1'b0;
            rd_en_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge arb_clk) begin
      if (arb_rst) begin
         state_q   <= INIT;
         aref_en_q <= 1'b0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         aref_en_q <= aref_en_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
      end
   end

   // Pin mux follows the registered state so the granted controller sees its command on the pins
   // in the same cycle its *_en is high.
   always_comb begin
      cmd_sel  = CMD_NOP;
      ba_sel   = '1;
      addr_sel = '1;
      case (state_q)
         INIT: begin
            cmd_sel  = bus.init_cmd;
            ba_sel   = bus.init_bank;
            addr_sel = bus.init_addr;
         end
         AREF: begin
            cmd_sel  = bus.aref_cmd;
            ba_sel   = bus.aref_bank;
            addr_sel = bus.aref_addr;
         end
         WRITE: begin
            cmd_sel  = bus.wr_cmd;
            ba_sel   = bus.wr_bank;
            addr_sel = bus.wr_addr;
         end
         READ: begin
            cmd_sel  = bus.rd_cmd;
            ba_sel   = bus.rd_bank;
            addr_sel = bus.rd_addr;
         end
         default: begin
            cmd_sel  = CMD_NOP;
            ba_sel   = '1;
            addr_sel = '1;
         end
      endcase
   end

   assign bus.aref_en     = aref_en_q;
   assign bus.wr_en       = wr_en_q;
   assign bus.rd_en       = rd_en_q;
   assign bus.sdram_cke   = 1'b1;
   assign bus.sdram_cs_n  = cmd_sel[3];
   assign bus.sdram_ras_n = cmd_sel[2];
   assign bus.sdram_cas_n = cmd_sel[1];
   assign bus.sdram_we_n  = cmd_sel[0];
   assign bus.sdram_ba    = ba_sel;
   assign bus.sdram_addr  = addr_sel;

   assign sdram_dq = (bus.wr_sdram_en && (state_q == WRITE)) ? bus.wr_sdram_data : {DATA_W{1'bz}};

endmodule
